// File: rtl/latch_word_serializer.sv
// ---------------------------------------------------------------------------
// latch_word_serializer
//
// Purpose:
//   Serial end of the latch word path. A parallel word is captured through a
//   load/ready handshake and then drained onto a single serial line. One bit
//   leaves per enable tick. An optional even/odd parity bit follows the data,
//   and a one-cycle done pulse closes the frame. All outputs are registered.
//
// Parameters:
//   WIDTH      data word width in bits (2..32)
//   LSB_FIRST  1 = bit 0 first (shift right), 0 = bit WIDTH-1 first (shift left)
//   PARITY     0 = none, 1 = even parity bit appended, 2 = odd parity bit appended
//
// Ports:
//   clk         rising-edge clock
//   reset_n     synchronous reset, active-low
//   d           parallel word, sampled only on an accepted load
//   load        request to capture d
//   ready       high when a load will be accepted this cycle
//   enable      bit-rate tick; each enabled edge in SHIFT emits one bit
//   sout        serial data bit
//   sout_valid  one-cycle strobe per emitted bit
//   last        qualifies sout_valid on the final bit of the frame
//   done        one-cycle pulse the cycle after the final bit
// ---------------------------------------------------------------------------
module latch_word_serializer #(
    parameter int WIDTH     = 8,
    parameter int LSB_FIRST = 1,
    parameter int PARITY    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    input  logic             load,
    output logic             ready,
    input  logic             enable,
    output logic             sout,
    output logic             sout_valid,
    output logic             last,
    output logic             done
);

    // Frame length: data bits plus the optional parity bit.
    localparam int N     = WIDTH + ((PARITY != 0) ? 1 : 0);
    localparam int CNT_W = $clog2(N + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               par_q, par_d;
    logic               sout_q, sout_d;
    logic               sout_valid_q, sout_valid_d;
    logic               last_q, last_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;

    // Bit presented by the shift register and the register after one shift.
    logic               data_bit;
    logic [WIDTH-1:0]   shreg_shifted;
    logic               parity_bit;
    logic               in_parity;
    logic               is_final;

    always_comb begin
        if (LSB_FIRST != 0) begin
            data_bit      = shreg_q[0];
            shreg_shifted = shreg_q >> 1;
        end else begin
            data_bit      = shreg_q[WIDTH-1];
            shreg_shifted = shreg_q << 1;
        end
        // The accumulator holds the XOR of the data bits; odd parity inverts it.
        parity_bit = (PARITY == 2) ? ~par_q : par_q;
        in_parity  = (PARITY != 0) && (cnt_q == CNT_W'(WIDTH));
        is_final   = (cnt_q == CNT_W'(N - 1));
    end

    always_comb begin
        state_d      = state_q;
        shreg_d      = shreg_q;
        cnt_d        = cnt_q;
        par_d        = par_q;
        sout_d       = sout_q;
        sout_valid_d = 1'b0;
        last_d       = 1'b0;
        done_d       = 1'b0;
        ready_d      = ready_q;

        case (state_q)
            ST_IDLE: begin
                // ready is held low through the done-pulse cycle (spent in
                // IDLE), so the accept is gated by ready_q, not by the state.
                if (load && ready_q) begin
                    shreg_d = d;
                    cnt_d   = '0;
                    par_d   = 1'b0;
                    state_d = ST_SHIFT;
                    ready_d = 1'b0;
                end else begin
                    ready_d = 1'b1;
                end
            end

            ST_SHIFT: begin
                ready_d = 1'b0;
                if (enable) begin
                    sout_valid_d = 1'b1;
                    cnt_d        = cnt_q + 1'b1;
                    if (in_parity) begin
                        sout_d = parity_bit;
                    end else begin
                        sout_d  = data_bit;
                        par_d   = par_q ^ data_bit;
                        shreg_d = shreg_shifted;
                    end
                    if (is_final) begin
                        last_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                // DONE is occupied while the final bit is on the line; the
                // pulse appears in the following cycle.
                done_d  = 1'b1;
                ready_d = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            shreg_q      <= '0;
            cnt_q        <= '0;
            par_q        <= 1'b0;
            sout_q       <= 1'b0;
            sout_valid_q <= 1'b0;
            last_q       <= 1'b0;
            done_q       <= 1'b0;
            ready_q      <= 1'b1;
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            par_q        <= par_d;
            sout_q       <= sout_d;
            sout_valid_q <= sout_valid_d;
            last_q       <= last_d;
            done_q       <= done_d;
            ready_q      <= ready_d;
        end
    end

    assign ready      = ready_q;
    assign sout       = sout_q;
    assign sout_valid = sout_valid_q;
    assign last       = last_q;
    assign done       = done_q;

endmodule

// File: tb/tb_latch_word_serializer.sv
// ---------------------------------------------------------------------------
// tb_latch_word_serializer
//
// Four serializer instances share the inputs and differ in configuration:
//   u0: LSB first, no parity   u1: MSB first, no parity
//   u2: LSB first, even parity u3: LSB first, odd parity
// Expected {last, bit} pairs are queued per instance when a word is loaded and
// consumed by a monitor as each sout_valid strobe appears.
// ---------------------------------------------------------------------------
module tb_latch_word_serializer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       load;
    logic       enable;
    logic [7:0] d;

    logic ready [4];
    logic sout  [4];
    logic sv    [4];
    logic last  [4];
    logic done  [4];

    always #5 clk = ~clk;

    latch_word_serializer #(.WIDTH(8), .LSB_FIRST(1), .PARITY(0)) u0 (
        .clk(clk), .reset_n(reset_n), .d(d), .load(load), .ready(ready[0]),
        .enable(enable), .sout(sout[0]), .sout_valid(sv[0]), .last(last[0]), .done(done[0]));
    latch_word_serializer #(.WIDTH(8), .LSB_FIRST(0), .PARITY(0)) u1 (
        .clk(clk), .reset_n(reset_n), .d(d), .load(load), .ready(ready[1]),
        .enable(enable), .sout(sout[1]), .sout_valid(sv[1]), .last(last[1]), .done(done[1]));
    latch_word_serializer #(.WIDTH(8), .LSB_FIRST(1), .PARITY(1)) u2 (
        .clk(clk), .reset_n(reset_n), .d(d), .load(load), .ready(ready[2]),
        .enable(enable), .sout(sout[2]), .sout_valid(sv[2]), .last(last[2]), .done(done[2]));
    latch_word_serializer #(.WIDTH(8), .LSB_FIRST(1), .PARITY(2)) u3 (
        .clk(clk), .reset_n(reset_n), .d(d), .load(load), .ready(ready[3]),
        .enable(enable), .sout(sout[3]), .sout_valid(sv[3]), .last(last[3]), .done(done[3]));

    int checks = 0;
    int errors = 0;

    logic [1:0] exp_q [4][$];
    logic [1:0] mon_e;

    int   sv_cnt      [4];
    int   first_sv    [4];
    int   last_cyc    [4];
    int   done_cnt    [4];
    int   done_cyc    [4];
    int   ready_cyc   [4];
    int   gap_changes [4];
    logic prev_sout   [4];
    bit   timed_out;

    function automatic int frame_len(input int k);
        return (k >= 2) ? 9 : 8;
    endfunction

    // Reference model: bit order and parity per instance configuration.
    task automatic push_frame(input logic [7:0] w);
        logic b, lb, p;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 8; i++) begin
                b  = (k != 1) ? w[i] : w[7-i];
                lb = (i == frame_len(k) - 1);
                exp_q[k].push_back({lb, b});
            end
            if (k >= 2) begin
                p = ^w;
                if (k == 3) p = ~p;
                exp_q[k].push_back({1'b1, p});
            end
        end
    endtask

    // Drive a load request for the next edge; call from a negedge.
    task automatic load_all(input logic [7:0] w, input logic en);
        d      = w;
        load   = 1'b1;
        enable = en;
        push_frame(w);
    endtask

    // Clock through one frame, recording per-instance event timing.
    // mode 0: enable tied high; mode 1: enable pattern 1,0,0,1.
    task automatic run_frame(input int mode, input int budget, input int busy_cyc);
        bit all_ready;
        for (int k = 0; k < 4; k++) begin
            sv_cnt[k] = 0; first_sv[k] = -1; last_cyc[k] = -1; done_cnt[k] = 0;
            done_cyc[k] = -1; ready_cyc[k] = -1; gap_changes[k] = 0;
            prev_sout[k] = sout[k];
        end
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            all_ready = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (sv[k] === 1'b1) begin
                    sv_cnt[k]++;
                    if (first_sv[k] < 0) first_sv[k] = c;
                    if (last[k] === 1'b1) last_cyc[k] = c;
                end
                if (done[k] === 1'b1) begin
                    done_cnt[k]++;
                    done_cyc[k] = c;
                end
                if (ready[k] === 1'b1 && done_cyc[k] >= 0 && ready_cyc[k] < 0) ready_cyc[k] = c;
                if (sv[k] !== 1'b1 && sout[k] !== prev_sout[k]) gap_changes[k]++;
                prev_sout[k] = sout[k];
                if (ready_cyc[k] < 0) all_ready = 1'b0;
            end
            load   = (c == busy_cyc);
            d      = (c == busy_cyc) ? 8'h55 : 8'h00;
            enable = (mode == 0) ? 1'b1 : ((c % 4 == 0) || (c % 4 == 3));
            if (all_ready) begin
                timed_out = 1'b0;
                break;
            end
        end
        load = 1'b0;
    endtask

    // Scoreboard monitor: every emitted bit must match the next queued entry.
    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (sv[k] === 1'b1) begin
                checks++;
                if (exp_q[k].size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_bit u%0d got sout=%b last=%b required no bit", k, sout[k], last[k]);
                end else begin
                    mon_e = exp_q[k].pop_front();
                    if ({last[k], sout[k]} !== mon_e) begin
                        errors++;
                        $display("FAIL serial_bit u%0d got last,sout=%b%b required %b", k, last[k], sout[k], mon_e);
                    end
                end
            end
        end
    end

    task automatic test_reset;
        reset_n = 1'b0; load = 1'b1; d = 8'hFF; enable = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++; if (ready[k] !== 1'b1) begin errors++; $display("FAIL reset_ready u%0d got %b required 1", k, ready[k]); end
            checks++; if (sout[k] !== 1'b0) begin errors++; $display("FAIL reset_sout u%0d got %b required 0", k, sout[k]); end
            checks++; if (sv[k] !== 1'b0) begin errors++; $display("FAIL reset_valid u%0d got %b required 0", k, sv[k]); end
            checks++; if (last[k] !== 1'b0) begin errors++; $display("FAIL reset_last u%0d got %b required 0", k, last[k]); end
            checks++; if (done[k] !== 1'b0) begin errors++; $display("FAIL reset_done u%0d got %b required 0", k, done[k]); end
        end
        reset_n = 1'b1; load = 1'b0; enable = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++; if (ready[k] !== 1'b1) begin errors++; $display("FAIL post_reset_ready u%0d got %b required 1", k, ready[k]); end
        end
        $display("reset: outputs at reset values, ready=1");
    endtask

    // Standard end-of-frame checks, written out in each scenario.
    task automatic test_lsb_first;
        for (int k = 0; k < 4; k++) begin
            checks++; if (ready[k] !== 1'b1) begin errors++; $display("FAIL a5_ready u%0d got %b required 1", k, ready[k]); end
        end
        load_all(8'hA5, 1'b1);
        run_frame(0, 40, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL a5_timeout got timeout required frame end"); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (first_sv[k] !== 1) begin errors++; $display("FAIL a5_first_bit u%0d got cycle %0d required 1", k, first_sv[k]); end
            checks++; if (sv_cnt[k] !== frame_len(k)) begin errors++; $display("FAIL a5_bits u%0d got %0d required %0d", k, sv_cnt[k], frame_len(k)); end
            checks++; if (last_cyc[k] !== frame_len(k)) begin errors++; $display("FAIL a5_last u%0d got cycle %0d required %0d", k, last_cyc[k], frame_len(k)); end
            checks++; if (done_cnt[k] !== 1 || done_cyc[k] !== last_cyc[k] + 1) begin errors++; $display("FAIL a5_done u%0d got %0d pulses at %0d required 1 at %0d", k, done_cnt[k], done_cyc[k], last_cyc[k] + 1); end
            checks++; if (ready_cyc[k] !== done_cyc[k] + 1) begin errors++; $display("FAIL a5_ready_back u%0d got cycle %0d required %0d", k, ready_cyc[k], done_cyc[k] + 1); end
            checks++; if (exp_q[k].size() != 0) begin errors++; $display("FAIL a5_missing u%0d got %0d bits left required 0", k, exp_q[k].size()); end
        end
        $display("lsb_first: word a5 framed, last/done/ready timing checked");
    endtask

    task automatic test_msb_first;
        @(negedge clk);
        load_all(8'h81, 1'b1);
        run_frame(0, 40, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL msb_timeout got timeout required frame end"); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (sv_cnt[k] !== frame_len(k)) begin errors++; $display("FAIL msb_bits u%0d got %0d required %0d", k, sv_cnt[k], frame_len(k)); end
            checks++; if (done_cnt[k] !== 1) begin errors++; $display("FAIL msb_done u%0d got %0d required 1", k, done_cnt[k]); end
            checks++; if (exp_q[k].size() != 0) begin errors++; $display("FAIL msb_missing u%0d got %0d bits left required 0", k, exp_q[k].size()); end
        end
        $display("msb_first: word 81 framed");
    endtask

    task automatic test_parity;
        @(negedge clk);
        load_all(8'h07, 1'b1);
        run_frame(0, 40, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL parity_timeout got timeout required frame end"); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (sv_cnt[k] !== frame_len(k)) begin errors++; $display("FAIL parity_bits u%0d got %0d required %0d", k, sv_cnt[k], frame_len(k)); end
            checks++; if (last_cyc[k] !== frame_len(k)) begin errors++; $display("FAIL parity_last u%0d got cycle %0d required %0d", k, last_cyc[k], frame_len(k)); end
            checks++; if (exp_q[k].size() != 0) begin errors++; $display("FAIL parity_missing u%0d got %0d bits left required 0", k, exp_q[k].size()); end
        end
        $display("parity: word 07 framed with even/odd parity");
    endtask

    task automatic test_stall;
        @(negedge clk);
        load_all(8'h3C, 1'b1);
        run_frame(1, 80, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL stall_timeout got timeout required frame end"); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (sv_cnt[k] !== frame_len(k)) begin errors++; $display("FAIL stall_bits u%0d got %0d required %0d", k, sv_cnt[k], frame_len(k)); end
            checks++; if (gap_changes[k] !== 0) begin errors++; $display("FAIL stall_sout_hold u%0d got %0d changes required 0", k, gap_changes[k]); end
            checks++; if (done_cyc[k] !== last_cyc[k] + 1) begin errors++; $display("FAIL stall_done u%0d got cycle %0d required %0d", k, done_cyc[k], last_cyc[k] + 1); end
            checks++; if (exp_q[k].size() != 0) begin errors++; $display("FAIL stall_missing u%0d got %0d bits left required 0", k, exp_q[k].size()); end
        end
        $display("stall: word 3c with enable gaps");
    endtask

    task automatic test_busy_load;
        @(negedge clk);
        load_all(8'hF0, 1'b1);
        run_frame(0, 40, 3);
        checks++; if (timed_out) begin errors++; $display("FAIL busy_timeout got timeout required frame end"); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (sv_cnt[k] !== frame_len(k) || done_cnt[k] !== 1) begin errors++; $display("FAIL busy_frame u%0d got %0d bits %0d done required %0d bits 1 done", k, sv_cnt[k], done_cnt[k], frame_len(k)); end
        end
        // No second frame may start from the ignored load.
        repeat (12) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                checks++; if (ready[k] !== 1'b1 || done[k] !== 1'b0) begin errors++; $display("FAIL busy_idle u%0d got ready=%b done=%b required 1 0", k, ready[k], done[k]); end
            end
        end
        $display("busy_load: load 55 during f0 frame ignored");
    endtask

    task automatic test_mid_reset;
        int seen;
        bit hit;
        @(negedge clk);
        load_all(8'hFF, 1'b1);
        seen = 0;
        hit  = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            load = 1'b0;
            if (sv[0] === 1'b1) seen++;
            if (seen == 3) begin
                hit = 1'b1;
                break;
            end
        end
        checks++; if (!hit) begin errors++; $display("FAIL midreset_timeout got %0d bits required 3", seen); end
        reset_n = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++; if (sout[k] !== 1'b0 || sv[k] !== 1'b0 || last[k] !== 1'b0) begin errors++; $display("FAIL midreset_out u%0d got sout=%b valid=%b last=%b required 0 0 0", k, sout[k], sv[k], last[k]); end
            checks++; if (ready[k] !== 1'b1 || done[k] !== 1'b0) begin errors++; $display("FAIL midreset_ctl u%0d got ready=%b done=%b required 1 0", k, ready[k], done[k]); end
            exp_q[k].delete();
        end
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                checks++; if (done[k] !== 1'b0) begin errors++; $display("FAIL midreset_no_done u%0d got %b required 0", k, done[k]); end
            end
        end
        load_all(8'h01, 1'b1);
        run_frame(0, 40, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL after_reset_timeout got timeout required frame end"); end
        for (int k = 0; k < 4; k++) begin
            checks++; if (sv_cnt[k] !== frame_len(k) || done_cnt[k] !== 1) begin errors++; $display("FAIL after_reset_frame u%0d got %0d bits %0d done required %0d bits 1 done", k, sv_cnt[k], done_cnt[k], frame_len(k)); end
            checks++; if (exp_q[k].size() != 0) begin errors++; $display("FAIL after_reset_missing u%0d got %0d bits left required 0", k, exp_q[k].size()); end
        end
        $display("mid_reset: frame ff aborted, word 01 framed afterwards");
    endtask

    initial begin
        reset_n = 1'b0;
        load    = 1'b0;
        enable  = 1'b0;
        d       = 8'h00;
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_parity();
        test_stall();
        test_busy_load();
        test_mid_reset();
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion required finish");
        $fatal(1, "watchdog expired");
    end

endmodule
